// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer.
package ser_pkg;

  localparam int unsigned DEFAULT_W = 6;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out bus of the bit serializer.
// master: word producer and serial consumer; slave: the serializer itself.
interface bit_serializer_if
  import ser_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
);

  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         a;
  logic         a_valid;
  logic         frame_start;
  logic         busy;

  modport master (
    output din, din_valid,
    input  din_ready, a, a_valid, frame_start, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, a, a_valid, frame_start, busy
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: W-bit words in over valid/ready, MSB-first bits out
// on `a`, gapless between back-to-back words.
// Build option SER_PARITY_EN appends an even-parity bit to every word.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned W        = DEFAULT_W,
  parameter logic        IDLE_BIT = 1'b0
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
  localparam int unsigned FRAME_LEN = W + 1;
`else
  localparam int unsigned FRAME_LEN = W;
`endif
  localparam int unsigned    CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic [W-1:0]     sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_bit;
  logic             ready;
  logic             xfer;
  logic             data_bit;

`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  // Handshake decode: ready depends only on registered state and reset
  always_comb begin
    last_bit = (cnt_q == CNT_LAST);
    ready    = !reset && ((state_q == S_IDLE) || ((state_q == S_SHIFT) && last_bit));
    xfer     = ready && bus.din_valid;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit && !xfer) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift register and bit counter: load on transfer, otherwise shift mid-frame
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (xfer) begin
      sr_q  <= bus.din;
      cnt_q <= '0;
    end else if ((state_q == S_SHIFT) && !last_bit) begin
      sr_q  <= {sr_q[W-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SER_PARITY_EN
  // Parity of the accepted word, captured at load and held for the trailer bit
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (xfer) begin
      par_q <= ^bus.din;
    end
  end

  // Data bit: word bits first, parity in the final slot
  always_comb begin
    data_bit = sr_q[W-1];
    if (cnt_q == CNT_W'(W)) begin
      data_bit = par_q;
    end
  end
`else
  // Data bit: current MSB of the shift register
  always_comb begin
    data_bit = sr_q[W-1];
  end
`endif

  // Output decode; reset forces idle outputs immediately
  always_comb begin
    bus.din_ready   = ready;
    bus.a           = IDLE_BIT;
    bus.a_valid     = 1'b0;
    bus.frame_start = 1'b0;
    bus.busy        = 1'b0;
    if (!reset && (state_q == S_SHIFT)) begin
      bus.a           = data_bit;
      bus.a_valid     = 1'b1;
      bus.frame_start = (cnt_q == '0);
      bus.busy        = 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer; adapts to the SER_PARITY_EN build.
module tb_bit_serializer;
  import ser_pkg::*;

  localparam int unsigned W = 6;
`ifdef SER_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bit_serializer_if #(.W(W)) bus ();

  bit_serializer #(
    .W        (W),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] cap;
  int          nvalid;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ea, input logic eav,
                         input logic erdy, input logic efs, input logic ebusy);
    chk({tag, ".a"},           bus.a,           ea);
    chk({tag, ".a_valid"},     bus.a_valid,     eav);
    chk({tag, ".din_ready"},   bus.din_ready,   erdy);
    chk({tag, ".frame_start"}, bus.frame_start, efs);
    chk({tag, ".busy"},        bus.busy,        ebusy);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Walks one full frame of word w; din_valid = hold_valid on non-final bits,
  // and last_valid/last_din are presented on the final bit.
  task automatic chk_frame(input string tag, input logic [W-1:0] w, input logic hold_valid,
                           input logic last_valid, input logic [W-1:0] last_din);
    logic exp_bit;
    for (int i = 0; i < int'(FL); i++) begin
      if (i == int'(FL) - 1) begin
        bus.din_valid = last_valid;
        bus.din       = last_din;
      end else begin
        bus.din_valid = hold_valid;
      end
      @(negedge clk);
      if (i < int'(W)) exp_bit = w[int'(W) - 1 - i];
      else             exp_bit = ^w;
      chk_out(tag, exp_bit, 1'b1, (i == int'(FL) - 1), (i == 0), 1'b1);
      cap = {cap[14:0], bus.a};
      if (bus.a_valid) nvalid++;
      next_cycle();
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = '0;

    // Reset held with din_valid high: no readiness, idle line
    next_cycle();
    @(negedge clk);
    chk_out("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_out("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    reset         = 1'b0;
    bus.din_valid = 1'b0;
    @(negedge clk);
    chk_out("rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Single word 101101
    bus.din       = 6'b101101;
    bus.din_valid = 1'b1;
    @(negedge clk);
    chk_out("sw.idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    cap = '0; nvalid = 0;
    chk_frame("sw", 6'b101101, 1'b0, 1'b0, 6'b000000);
    @(negedge clk);
    chk_out("sw.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_vec("sw.nvalid", 16'(nvalid), 16'(FL));
`ifndef SER_PARITY_EN
    chk_vec("sw.bits", {10'b0, cap[5:0]}, 16'b0000000000101101);
`endif
    next_cycle();

    // Back-to-back 111000 then 000111 with din_valid held high
    bus.din       = 6'b111000;
    bus.din_valid = 1'b1;
    @(negedge clk);
    chk_out("bb.idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    cap = '0; nvalid = 0;
    chk_frame("bb0", 6'b111000, 1'b1, 1'b1, 6'b000111);
    chk_frame("bb1", 6'b000111, 1'b1, 1'b0, 6'b000000);
    @(negedge clk);
    chk_out("bb.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_vec("bb.nvalid", 16'(nvalid), 16'(2 * FL));
`ifndef SER_PARITY_EN
    chk_vec("bb.bits", {4'b0, cap[11:0]}, 16'b0000111000000111);
`endif
    next_cycle();

    // Stall: valid low on last bit of 010101 returns to idle
    bus.din       = 6'b010101;
    bus.din_valid = 1'b1;
    next_cycle();
    chk_frame("st", 6'b010101, 1'b0, 1'b0, 6'b111111);
    @(negedge clk);
    chk_out("st.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Reset during bit 3 of 110011 discards the rest of the word
    bus.din       = 6'b110011;
    bus.din_valid = 1'b1;
    next_cycle();
    bus.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("rm.bit", (i < 2) ? 1'b1 : 1'b0, 1'b1, 1'b0, (i == 0), 1'b1);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    chk_out("rm.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("rm.idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    bus.din       = 6'b000001;
    bus.din_valid = 1'b1;
    next_cycle();
    cap = '0; nvalid = 0;
    chk_frame("rm.new", 6'b000001, 1'b0, 1'b0, 6'b000000);
`ifndef SER_PARITY_EN
    chk_vec("rm.bits", {10'b0, cap[5:0]}, 16'b0000000000000001);
`endif
    @(negedge clk);
    chk_out("rm.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();

`ifdef SER_PARITY_EN
    // Parity trailer: 101100 -> 1011001, ready on the 7th bit
    bus.din       = 6'b101100;
    bus.din_valid = 1'b1;
    next_cycle();
    cap = '0; nvalid = 0;
    chk_frame("par", 6'b101100, 1'b0, 1'b0, 6'b000000);
    chk_vec("par.bits", {9'b0, cap[6:0]}, 16'b0000000001011001);
    chk_vec("par.nvalid", 16'(nvalid), 16'd7);
    @(negedge clk);
    chk_out("par.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
